instr_decode_stage: RTL
=======================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter DEPTH, default 2: buffer entries; only value 2 supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  instruction word offered.
REQ-005 in_instr  in  16  raw instruction word.
REQ-006 in_ready  out  1  stage can accept this cycle.
REQ-007 flush  in  1  discard all buffered entries.
REQ-008 out_valid  out  1  decoded entry at head.
REQ-009 out_ready  in  1  execute stage consumes head.
REQ-010 out_alu_op  out  3  ADD=0, SUB=1, AND=2, OR=3, SLT=4.
REQ-011 out_rs, out_rt, out_rd  out  2 each  source A, source B, destination register.
REQ-012 out_imm  out  16  extended immediate.
REQ-013 out_use_imm, out_reg_write, out_mem_rd, out_mem_wr, out_branch, out_illegal  out  1 each  control flags.
REQ-014 illegal_count  out  8  saturating count of illegal words accepted.

Function
REQ-015 Fields: opcode[15:12], rs[11:10], rt[9:8], imm8[7:0]; R-type adds rd[7:6], funct[3:0].
REQ-016 Opcode 0000 (R-type): funct 0000..0100 -> ADD, SUB, AND, OR, SLT; use_imm=0, reg_write=1, rd=instr[7:6].
REQ-017 Opcodes 0001 ADDI, 0010 ANDI, 0011 ORI, 0100 SLTI -> ADD, AND, OR, SLT; use_imm=1, reg_write=1, rd=rt.
REQ-018 Opcode 0101 LW: ADD, use_imm=1, mem_rd=1, reg_write=1, rd=rt; 0110 SW: ADD, use_imm=1, mem_wr=1, reg_write=0.
REQ-019 Opcode 0111 BEQ: SUB, use_imm=0, branch=1, reg_write=0; out_imm carries offset.
REQ-020 Immediate: sign-extend imm8 for ADDI, SLTI, LW, SW, BEQ; zero-extend for ANDI, ORI; 0x0000 for R-type.
REQ-021 Illegal: opcodes 1000..1111 or R-type funct > 0100 -> out_illegal=1, all other flags 0, alu_op=0, imm=0; entry still flows in order.
REQ-022 When reg_write=0, out_rd=0.
REQ-023 Decode occurs on acceptance; decoded fields stored in a 2-entry in-order buffer.
REQ-024 Handshake: accept when in_valid && in_ready; pop when out_valid && out_ready.
REQ-025 in_ready = (count != 2) && !flush; out_valid = (count != 0).
REQ-026 Latency: word accepted at edge N is visible on outputs after edge N (next cycle) if buffer was empty.
REQ-027 Simultaneous push and pop at count 1: count stays 1, new entry becomes head next cycle; full throughput 1/cycle.
REQ-028 At count 2 no push occurs; pop reduces count to 1.
REQ-029 Outputs hold stable while out_valid && !out_ready.
REQ-030 flush: next edge sets count=0, discards any pop/push that cycle; illegal_count not incremented for that cycle's word.
REQ-031 illegal_count increments by 1 on each accepted illegal word, saturates at 0xFF; not cleared by flush.
REQ-032 Pointer wrap: read/write pointers 1 bit, wrap 1->0.

Reset
REQ-033 reset_n low: count=0, pointers=0, illegal_count=0, out_valid=0, in_ready=0 while asserted; all decoded outputs 0.
REQ-034 Reset mid-operation discards buffered entries immediately (asynchronous); in_ready=1 on first cycle after release.

Verification
REQ-035 SLTI 0x49FD accepted, out_ready=1 -> next cycle alu_op=4, rs=2, rt=1, rd=1, imm=0xFFFD, use_imm=1, reg_write=1.
REQ-036 ANDI 0x2380 -> imm=0x0080, alu_op=2, rd=3; SLT 0x06C4 -> alu_op=4, rs=1, rt=2, rd=3, use_imm=0.
REQ-037 out_ready=0, push 0x49FD, 0x2380, 0x06C4 -> third refused (in_ready=0 at count 2); release -> SLTI, ANDI emitted in order.
REQ-038 0xF000 and 0x0005 accepted -> out_illegal=1, reg_write=0, illegal_count=2; 256 illegal words -> illegal_count=0xFF.
REQ-039 Buffer full, flush=1 -> out_valid=0 next cycle, in_ready=1, illegal_count unchanged.
REQ-040 reset_n low with count=2 -> out_valid=0 immediately without clock edge; streaming 10 back-to-back words with out_ready=1 -> one output per cycle.

Source files
------------

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decodes 16-bit instruction words on acceptance into a
// 2-entry in-order buffer feeding the execute stage, with a saturating illegal-word count.
module instr_decode_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_alu_op,
  output logic [1:0]  out_rs,
  output logic [1:0]  out_rt,
  output logic [1:0]  out_rd,
  output logic [15:0] out_imm,
  output logic        out_use_imm,
  output logic        out_reg_write,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic        out_branch,
  output logic        out_illegal,
  output logic [7:0]  illegal_count
);
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3, SLT = 3'd4;
  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef struct packed {
    logic [2:0]  alu_op;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [1:0]  rd;
    logic [15:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        illegal;
  } dec_t;

  dec_t [1:0] mem;
  dec_t       dec, head;
  logic [1:0] count;
  logic       wp, rp, push, pop;
  logic [3:0] op, funct;
  logic [15:0] sx, zx;

  assign op    = in_instr[15:12];
  assign funct = in_instr[3:0];
  assign sx    = {{8{in_instr[7]}}, in_instr[7:0]};
  assign zx    = {8'h00, in_instr[7:0]};

  always_comb begin
    dec    = '0;
    dec.rs = in_instr[11:10];
    dec.rt = in_instr[9:8];
    case (op)
      4'h0: begin
        dec.illegal   = funct > 4'd4;
        dec.alu_op    = dec.illegal ? ADD : funct[2:0];
        dec.reg_write = !dec.illegal;
        dec.rd        = dec.illegal ? 2'd0 : in_instr[7:6];
      end
      4'h1, 4'h4: begin
        dec.alu_op    = op == 4'h1 ? ADD : SLT;
        dec.imm       = sx;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = in_instr[9:8];
      end
      4'h2, 4'h3: begin
        dec.alu_op    = op == 4'h2 ? AND : OR;
        dec.imm       = zx;
        dec.use_imm   = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = in_instr[9:8];
      end
      4'h5: begin
        dec.imm       = sx;
        dec.use_imm   = 1'b1;
        dec.mem_rd    = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = in_instr[9:8];
      end
      4'h6: begin
        dec.imm     = sx;
        dec.use_imm = 1'b1;
        dec.mem_wr  = 1'b1;
      end
      4'h7: begin
        dec.alu_op = SUB;
        dec.imm    = sx;
        dec.branch = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // in_ready is forced low during reset, not just by the cleared count
  assign in_ready  = reset_n && count != FULL && !flush;
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem           <= '0;
      count         <= '0;
      wp            <= 1'b0;
      rp            <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      count <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= dec;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push && dec.illegal && illegal_count != 8'hFF) illegal_count <= illegal_count + 8'd1;
    end
  end

  assign head          = mem[rp];
  assign out_alu_op    = head.alu_op;
  assign out_rs        = head.rs;
  assign out_rt        = head.rt;
  assign out_rd        = head.rd;
  assign out_imm       = head.imm;
  assign out_use_imm   = head.use_imm;
  assign out_reg_write = head.reg_write;
  assign out_mem_rd    = head.mem_rd;
  assign out_mem_wr    = head.mem_wr;
  assign out_branch    = head.branch;
  assign out_illegal   = head.illegal;
endmodule
